muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: N_CYCLES, default 32, number of execution cycles granted to the multiplier/divider per operation (legal range 2..64).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 mult  input  1  one-cycle request from control unit to start a MULT.
REQ-005 div  input  1  one-cycle request from control unit to start a DIV.
REQ-006 B_in  input  32  divisor operand (B register output), checked for zero when div is sampled.
REQ-007 mult_start  output  1  one-cycle start pulse to multiplier.
REQ-008 div_start  output  1  one-cycle start pulse to divider.
REQ-009 busy  output  1  high while an operation is in progress; main control holds its state while busy.
REQ-010 Hi_write  output  1  write enable for Hi register.
REQ-011 Lo_write  output  1  write enable for Lo register.
REQ-012 hilo_src  output  1  Hi/Lo input select: 0 = multiplier result, 1 = divider result.
REQ-013 done  output  1  one-cycle completion pulse, coincident with Hi_write/Lo_write.
REQ-014 dzero  output  1  one-cycle divide-by-zero exception pulse to control unit.

Function
REQ-015 States: IDLE, MULT_RUN, DIV_RUN, WRITE, DZERO_EXC; state register plus down-counter of ceil(log2(N_CYCLES)) bits.
REQ-016 IDLE, mult=1 at edge E0: next state MULT_RUN, counter <= N_CYCLES-1, hilo_src <= 0.
REQ-017 IDLE, mult=0, div=1, B_in!=0 at E0: next state DIV_RUN, counter <= N_CYCLES-1, hilo_src <= 1.
REQ-018 IDLE, mult=0, div=1, B_in==0 at E0: next state DZERO_EXC; no start pulse, no Hi/Lo write.
REQ-019 mult and div both high in IDLE: mult wins; div ignored (not queued).
REQ-020 mult_start (div_start) high only in the first cycle of MULT_RUN (DIV_RUN), i.e. the cycle after E0.
REQ-021 In *_RUN: counter decrements each edge; at an edge with counter==0, next state WRITE.
REQ-022 WRITE lasts exactly one cycle (cycle after edge E0+N_CYCLES): Hi_write=Lo_write=done=1; next state IDLE.
REQ-023 DZERO_EXC lasts one cycle (cycle after E0): dzero=1, done=0; next state IDLE.
REQ-024 busy=1 in MULT_RUN, DIV_RUN, WRITE; busy=0 in IDLE and DZERO_EXC.
REQ-025 mult/div requests in any state other than IDLE are ignored and do not alter counter, hilo_src or state.
REQ-026 hilo_src holds its value from request acceptance until the next accepted request, so it is stable throughout WRITE.
REQ-027 Back-to-back: a request sampled on the edge leaving WRITE or DZERO_EXC is ignored; a new request is accepted from IDLE only, one cycle later at the earliest.
REQ-028 All outputs driven from registered state (Moore); no combinational path from mult, div or B_in to any output.

Reset
REQ-029 reset=1 at an edge forces IDLE, counter=0, hilo_src=0 in any state, including mid-RUN; aborted operation produces no Hi_write, Lo_write, done or dzero.
REQ-030 While in reset and the cycle after: mult_start, div_start, busy, Hi_write, Lo_write, done, dzero, hilo_src all 0.
REQ-031 reset has priority over simultaneous mult/div requests.

Structure
REQ-032 State encodings and hilo_src select values are localparams in a shared header under modulos/, included by muldiv_ctrl and the Hi/Lo source mux.
REQ-033 The down-counter is one sub-module, cycle_counter (load, decrement, zero flag); everything else stays in muldiv_ctrl.
REQ-034 Target size 120-400 lines RTL total.

Verification
REQ-035 Reset with mult=1 held: all outputs 0 and state IDLE; after release with mult=0, outputs stay 0.
REQ-036 N_CYCLES=4, mult pulse at edge 0 -> mult_start high after edge 0 only; busy high after edges 0..4; Hi_write=Lo_write=done=1 and hilo_src=0 only after edge 4; IDLE after edge 5.
REQ-037 N_CYCLES=32, div with B_in=32'h0000_0007 -> div_start one cycle, done/Hi_write/Lo_write one cycle after edge 32, hilo_src=1.
REQ-038 div with B_in=32'h0000_0000 -> dzero one cycle after request edge; busy, div_start, Hi_write, Lo_write, done stay 0.
REQ-039 mult and div high simultaneously, then div re-pulsed during MULT_RUN -> only mult executes, hilo_src=0, exactly one done pulse.
REQ-040 N_CYCLES=4, reset asserted after edge 2 of DIV_RUN -> IDLE next cycle, no Hi_write/done ever; a later mult completes normally.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the multiply/divide sequencing controller and for
// the Hi/Lo source mux that consumes hilo_src.
//   state_t        : controller FSM state encoding
//   HILO_SRC_MULT  : hilo_src value selecting the multiplier result
//   HILO_SRC_DIV   : hilo_src value selecting the divider result
// ---------------------------------------------------------------------------
package muldiv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MULT_RUN  = 3'd1,
      ST_DIV_RUN   = 3'd2,
      ST_WRITE     = 3'd3,
      ST_DZERO_EXC = 3'd4
   } state_t;

   localparam logic HILO_SRC_MULT = 1'b0;
   localparam logic HILO_SRC_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_ctrl_cycle_counter.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_cycle_counter
// Loadable down-counter that times one multiply/divide operation.
//   clk      : clock, all state on rising edge
//   reset    : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value loaded on load
//   dec      : decrement by one
//   zero     : count is zero (decoded from the count register)
// ---------------------------------------------------------------------------
module muldiv_ctrl_cycle_counter #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// Sequences one MULT or DIV operation: issues a start pulse, waits N_CYCLES
// cycles, then writes Hi/Lo for one cycle. A DIV with a zero divisor raises
// a one-cycle dzero exception instead of running.
//   clk        : clock
//   reset      : synchronous active-high reset
//   mult, div  : one-cycle requests (mult wins if both are high)
//   B_in       : divisor, tested for zero when div is accepted
//   mult_start : one-cycle multiplier start pulse
//   div_start  : one-cycle divider start pulse
//   busy       : operation in progress (RUN or WRITE)
//   Hi_write   : Hi register write enable
//   Lo_write   : Lo register write enable
//   hilo_src   : Hi/Lo input select (0 multiplier, 1 divider)
//   done       : completion pulse, coincident with Hi_write/Lo_write
//   dzero      : divide-by-zero exception pulse
// All outputs are flops, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int N_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mult,
   input  logic        div,
   input  logic [31:0] B_in,
   output logic        mult_start,
   output logic        div_start,
   output logic        busy,
   output logic        Hi_write,
   output logic        Lo_write,
   output logic        hilo_src,
   output logic        done,
   output logic        dzero
);

   localparam int CNT_W = $clog2(N_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_CYCLES - 1);

   state_t state_q, state_d;
   logic   hilo_src_q, hilo_src_d;
   logic   mult_start_q, mult_start_d;
   logic   div_start_q, div_start_d;
   logic   busy_q, busy_d;
   logic   write_q, write_d;
   logic   dzero_q, dzero_d;
   logic   cnt_load, cnt_dec, cnt_zero;

   muldiv_ctrl_cycle_counter #(
      .WIDTH (CNT_W)
   ) u_cycle_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (CNT_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d    = state_q;
      hilo_src_d = hilo_src_q;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mult) begin
               state_d    = ST_MULT_RUN;
               cnt_load   = 1'b1;
               hilo_src_d = HILO_SRC_MULT;
            end else if (div) begin
               if (B_in != 32'd0) begin
                  state_d    = ST_DIV_RUN;
                  cnt_load   = 1'b1;
                  hilo_src_d = HILO_SRC_DIV;
               end else begin
                  // hilo_src keeps the last accepted operation's select
                  state_d = ST_DZERO_EXC;
               end
            end
         end
         ST_MULT_RUN, ST_DIV_RUN: begin
            if (cnt_zero) begin
               state_d = ST_WRITE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_WRITE, ST_DZERO_EXC: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with
      // the state they describe (Moore timing, one flop per output).
      mult_start_d = (state_q == ST_IDLE) && (state_d == ST_MULT_RUN);
      div_start_d  = (state_q == ST_IDLE) && (state_d == ST_DIV_RUN);
      busy_d       = (state_d == ST_MULT_RUN) || (state_d == ST_DIV_RUN) ||
                     (state_d == ST_WRITE);
      write_d      = (state_d == ST_WRITE);
      dzero_d      = (state_d == ST_DZERO_EXC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         hilo_src_q   <= HILO_SRC_MULT;
         mult_start_q <= 1'b0;
         div_start_q  <= 1'b0;
         busy_q       <= 1'b0;
         write_q      <= 1'b0;
         dzero_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         hilo_src_q   <= hilo_src_d;
         mult_start_q <= mult_start_d;
         div_start_q  <= div_start_d;
         busy_q       <= busy_d;
         write_q      <= write_d;
         dzero_q      <= dzero_d;
      end
   end

   assign mult_start = mult_start_q;
   assign div_start  = div_start_q;
   assign busy       = busy_q;
   assign Hi_write   = write_q;
   assign Lo_write   = write_q;
   assign done       = write_q;
   assign hilo_src   = hilo_src_q;
   assign dzero      = dzero_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
// Self-checking bench for muldiv_ctrl with two instances (N_CYCLES=4 and 32).
// Expected completions (cycle, kind, source) are queued when a request is
// driven and popped when the DUT raises done or dzero.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        mult_a, div_a, mult_b, div_b;
   logic [31:0] b_a, b_b;
   logic        mult_start_a, div_start_a, busy_a, Hi_write_a, Lo_write_a;
   logic        hilo_src_a, done_a, dzero_a;
   logic        mult_start_b, div_start_b, busy_b, Hi_write_b, Lo_write_b;
   logic        hilo_src_b, done_b, dzero_b;

   muldiv_ctrl #(.N_CYCLES(4)) dut_n4 (
      .clk        (clk),
      .reset      (reset),
      .mult       (mult_a),
      .div        (div_a),
      .B_in       (b_a),
      .mult_start (mult_start_a),
      .div_start  (div_start_a),
      .busy       (busy_a),
      .Hi_write   (Hi_write_a),
      .Lo_write   (Lo_write_a),
      .hilo_src   (hilo_src_a),
      .done       (done_a),
      .dzero      (dzero_a)
   );

   muldiv_ctrl #(.N_CYCLES(32)) dut_n32 (
      .clk        (clk),
      .reset      (reset),
      .mult       (mult_b),
      .div        (div_b),
      .B_in       (b_b),
      .mult_start (mult_start_b),
      .div_start  (div_start_b),
      .busy       (busy_b),
      .Hi_write   (Hi_write_b),
      .Lo_write   (Lo_write_b),
      .hilo_src   (hilo_src_b),
      .done       (done_b),
      .dzero      (dzero_b)
   );

   typedef struct {
      int   due;
      logic src;
      logic dz;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   ecnt  = 0;

   task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   function automatic logic [7:0] outs_a();
      return {mult_start_a, div_start_a, busy_a, Hi_write_a,
              Lo_write_a, done_a, dzero_a, hilo_src_a};
   endfunction

   function automatic logic [7:0] outs_b();
      return {mult_start_b, div_start_b, busy_b, Hi_write_b,
              Lo_write_b, done_b, dzero_b, hilo_src_b};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Completion monitor for both instances; ecnt is the index of the
   // rising edge whose result is currently visible on the outputs.
   always begin
      exp_t e;
      @(posedge clk);
      ecnt++;
      #1;
      check_val("a_hilo_we", {62'd0, Hi_write_a, Lo_write_a}, {62'd0, done_a, done_a});
      check_val("b_hilo_we", {62'd0, Hi_write_b, Lo_write_b}, {62'd0, done_b, done_b});
      if (done_a || dzero_a) begin
         if (q_a.size() == 0) begin
            check_val("a_unexpected", {done_a, dzero_a}, 0);
         end else begin
            e = q_a.pop_front();
            check_val("a_cycle", ecnt, e.due);
            check_val("a_kind", dzero_a, e.dz);
            if (!e.dz) check_val("a_src", hilo_src_a, e.src);
            $display("txn n4: edge=%0d done=%0b dzero=%0b hilo_src=%0b", ecnt, done_a, dzero_a, hilo_src_a);
         end
      end
      if (done_b || dzero_b) begin
         if (q_b.size() == 0) begin
            check_val("b_unexpected", {done_b, dzero_b}, 0);
         end else begin
            e = q_b.pop_front();
            check_val("b_cycle", ecnt, e.due);
            check_val("b_kind", dzero_b, e.dz);
            if (!e.dz) check_val("b_src", hilo_src_b, e.src);
            $display("txn n32: edge=%0d done=%0b dzero=%0b hilo_src=%0b", ecnt, done_b, dzero_b, hilo_src_b);
         end
      end
   end

   task automatic wait_write_a(int budget);
      int k = 0;
      while (!Hi_write_a && k < budget) begin
         step();
         k++;
      end
      check_val("a_wait_write", Hi_write_a, 1);
   endtask

   initial begin
      exp_t e;
      int   k;
      reset = 1'b1;
      mult_a = 1'b1; div_a = 1'b0; b_a = 32'd0;
      mult_b = 1'b1; div_b = 1'b0; b_b = 32'd0;

      // Reset with mult held high
      repeat (3) begin
         step();
         check_val("rst_outs_a", outs_a(), 0);
         check_val("rst_outs_b", outs_b(), 0);
      end
      reset = 1'b0; mult_a = 1'b0; mult_b = 1'b0;
      repeat (2) begin
         step();
         check_val("post_rst_a", outs_a(), 0);
         check_val("post_rst_b", outs_b(), 0);
      end

      // MULT on N=4: start after edge 0, busy edges 0..4, write after edge 4
      mult_a = 1'b1;
      e = '{due: ecnt + 1 + 4, src: 1'b0, dz: 1'b0}; q_a.push_back(e);
      for (int i = 0; i <= 5; i++) begin
         step();
         if (i == 0) mult_a = 1'b0;
         check_val("m4_start", mult_start_a, (i == 0));
         check_val("m4_busy", busy_a, (i <= 4));
         check_val("m4_write", Hi_write_a, (i == 4));
         if (i == 4) check_val("m4_src", hilo_src_a, 0);
      end
      check_val("m4_idle", outs_a(), 0);

      // DIV by zero, then a mult on the edge leaving DZERO_EXC is ignored
      div_a = 1'b1; b_a = 32'd0;
      e = '{due: ecnt + 1, src: 1'b0, dz: 1'b1}; q_a.push_back(e);
      step();
      div_a = 1'b0;
      check_val("dz_pulse", dzero_a, 1);
      check_val("dz_quiet", {busy_a, div_start_a, Hi_write_a, Lo_write_a, done_a}, 0);
      mult_a = 1'b1;
      step();
      mult_a = 1'b0;
      check_val("dz_b2b_ignored", outs_a(), 0);
      step();
      check_val("dz_b2b_idle", outs_a(), 0);

      // mult+div together, div re-pulsed mid-run and on the edge leaving WRITE
      mult_a = 1'b1; div_a = 1'b1; b_a = 32'd5;
      e = '{due: ecnt + 1 + 4, src: 1'b0, dz: 1'b0}; q_a.push_back(e);
      step();
      mult_a = 1'b0; div_a = 1'b0;
      check_val("both_mstart", mult_start_a, 1);
      check_val("both_dstart", div_start_a, 0);
      div_a = 1'b1; b_a = 32'd6;
      step();
      div_a = 1'b0;
      check_val("run_div_ignored", div_start_a, 0);
      check_val("run_busy", busy_a, 1);
      wait_write_a(10);
      check_val("both_src", hilo_src_a, 0);
      div_a = 1'b1; b_a = 32'd3;
      step();
      div_a = 1'b0;
      check_val("wr_b2b_ignored", outs_a(), 0);
      step();
      check_val("wr_b2b_idle", outs_a(), 0);

      // DIV aborted by reset after edge 2 of DIV_RUN
      div_a = 1'b1; b_a = 32'd9;
      step();
      div_a = 1'b0;
      check_val("abort_dstart", div_start_a, 1);
      check_val("abort_src", hilo_src_a, 1);
      step();
      step();
      check_val("abort_busy", busy_a, 1);
      reset = 1'b1;
      step();
      check_val("abort_rst", outs_a(), 0);
      reset = 1'b0;
      step();
      check_val("abort_after", outs_a(), 0);
      repeat (4) step();
      check_val("abort_quiet", outs_a(), 0);

      // A later MULT completes normally
      mult_a = 1'b1;
      e = '{due: ecnt + 1 + 4, src: 1'b0, dz: 1'b0}; q_a.push_back(e);
      step();
      mult_a = 1'b0;
      check_val("late_mstart", mult_start_a, 1);
      wait_write_a(10);

      // DIV on N=32 with B_in=7
      div_b = 1'b1; b_b = 32'h0000_0007;
      e = '{due: ecnt + 1 + 32, src: 1'b1, dz: 1'b0}; q_b.push_back(e);
      step();
      div_b = 1'b0;
      check_val("d32_start", div_start_b, 1);
      check_val("d32_src", hilo_src_b, 1);
      check_val("d32_busy", busy_b, 1);
      step();
      check_val("d32_start_once", div_start_b, 0);
      k = 0;
      while (!done_b && k < 40) begin
         step();
         k++;
      end
      check_val("d32_done", {done_b, Hi_write_b, Lo_write_b, hilo_src_b}, 4'hF);

      repeat (3) step();
      check_val("q_a_empty", q_a.size(), 0);
      check_val("q_b_empty", q_b.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
